// File: rtl/systolic_feeder.sv
// Source-side feeder for the weight-stationary MAC array: weight preload, skewed activation streaming, zero flush.
// Optional FEEDER_STATS_EN adds a saturating stall counter output (stall_cnt).
module systolic_feeder #(
   parameter int DATA_SIZE  = 8,
   parameter int ARRAY_SIZE = 2,
   parameter int ROWS_W     = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [ROWS_W-1:0]              num_rows,
   input  logic                           w_valid,
   output logic                           w_ready,
   input  logic [ARRAY_SIZE*DATA_SIZE-1:0] w_data,
   input  logic                           x_valid,
   output logic                           x_ready,
   input  logic [ARRAY_SIZE*DATA_SIZE-1:0] x_data,
   output logic [ARRAY_SIZE*DATA_SIZE-1:0] b_out,
   output logic                           w_load,
   output logic [ARRAY_SIZE*DATA_SIZE-1:0] a_out,
   output logic [ARRAY_SIZE-1:0]          a_vld,
   output logic                           busy,
`ifdef FEEDER_STATS_EN
   output logic [31:0]                    stall_cnt,
`endif
   output logic                           done,
   output logic [2:0]                     dbg_state
);

   localparam int N     = ARRAY_SIZE;
   localparam int W     = N * DATA_SIZE;
   localparam int CNT_W = $clog2(2 * N) + 1;
   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0]  LAST_FLUSH = CNT_W'(2 * N - 2);
   localparam logic [CNT_W-1:0]  CNT_ONE    = 1;
   localparam logic [ROWS_W-1:0] ROW_ONE    = 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_FLUSH, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ROWS_W-1:0]   row_cnt_q, row_cnt_d;
   logic [ROWS_W-1:0]   num_rows_q, num_rows_d;
   logic [W-1:0]        b_out_q, b_out_d;
   logic                w_load_q, w_load_d;
   logic                w_beat, x_acc;
   logic [W-1:0]        s0_data;
   logic                s0_vld;

   // Handshake: a beat transfers on a cycle where valid and ready are both high;
   // ready depends only on registered state, never on the incoming valid.
   assign w_ready   = (state_q == S_LOAD_W);
   assign x_ready   = (state_q == S_STREAM) && (row_cnt_q != num_rows_q);
   assign w_beat    = w_valid && w_ready;
   assign x_acc     = x_valid && x_ready;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign b_out     = b_out_q;
   assign w_load    = w_load_q;
   assign dbg_state = state_q;

   // Stage-0 input: accepted row, otherwise a zero bubble so the array never stalls.
   assign s0_data = x_acc ? x_data : '0;
   assign s0_vld  = x_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         row_cnt_q  <= '0;
         num_rows_q <= '0;
         b_out_q    <= '0;
         w_load_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_cnt_q  <= row_cnt_d;
         num_rows_q <= num_rows_d;
         b_out_q    <= b_out_d;
         w_load_q   <= w_load_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      row_cnt_d  = row_cnt_q;
      num_rows_d = num_rows_q;
      b_out_d    = w_beat ? w_data : b_out_q;
      w_load_d   = w_beat;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_rows_d = num_rows;
               row_cnt_d  = '0;
               cnt_d      = '0;
               state_d    = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (w_beat) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = (num_rows_q == '0) ? S_FLUSH : S_STREAM;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         S_STREAM: begin
            if (x_acc) begin
               row_cnt_d = row_cnt_q + ROW_ONE;
               if (row_cnt_d == num_rows_q) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // 2N-1 zero cycles: the last row's lane N-1 leaves the skew, then its sum drains.
            if (cnt_q == LAST_FLUSH) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Lane k carries k+1 register stages, giving the diagonal wavefront.
   for (genvar k = 0; k < N; k++) begin : g_lane
      logic [DATA_SIZE-1:0] d_q [0:k];
      logic [k:0]           v_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i <= k; i++) d_q[i] <= '0;
            v_q <= '0;
         end else begin
            d_q[0] <= s0_data[k*DATA_SIZE +: DATA_SIZE];
            v_q[0] <= s0_vld;
            for (int i = 1; i <= k; i++) begin
               d_q[i] <= d_q[i-1];
               v_q[i] <= v_q[i-1];
            end
         end
      end

      assign a_out[k*DATA_SIZE +: DATA_SIZE] = d_q[k];
      assign a_vld[k]                        = v_q[k];
   end

`ifdef FEEDER_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == S_IDLE && start)
         stall_d = '0;
      else if (state_q == S_STREAM && !x_valid && stall_q != 32'hFFFF_FFFF)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`else
   // Statistics build option off: no stall counter in this configuration.
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=2, DATA_SIZE=8); define FEEDER_STATS_EN to also check stall_cnt.
module tb_systolic_feeder;
   localparam int N    = 2;
   localparam int DS   = 8;
   localparam int W    = N * DS;
   localparam int RW   = 16;
   localparam int MAXT = 128;
   localparam int MAXH = 4096;

   logic          clk, reset, start;
   logic [RW-1:0] num_rows;
   logic          w_valid, w_ready, x_valid, x_ready;
   logic [W-1:0]  w_data, x_data, b_out, a_out;
   logic          w_load, busy, done;
   logic [N-1:0]  a_vld;
   logic [2:0]    dbg_state;
`ifdef FEEDER_STATS_EN
   logic [31:0]   stall_cnt;
`endif

   systolic_feeder #(.DATA_SIZE(DS), .ARRAY_SIZE(N), .ROWS_W(RW)) dut (
      .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
      .b_out(b_out), .w_load(w_load), .a_out(a_out), .a_vld(a_vld),
      .busy(busy),
`ifdef FEEDER_STATS_EN
      .stall_cnt(stall_cnt),
`endif
      .done(done), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int base   = 0;
   int stall_exp = 0;
   logic [W-1:0] exp_b = '0;

   // Stage-0 history: what entered the skew on each cycle; cycles before base were wiped by reset.
   logic [W-1:0] hist_d [0:MAXH-1];
   logic         hist_v [0:MAXH-1];

   logic [W-1:0] w_rows [0:N-1];
   logic [W-1:0] x_rows [$];

   // Per-job timeline: stimulus and expected handshake/status per cycle.
   logic         tl_start [0:MAXT-1];
   logic         tl_wv    [0:MAXT-1];
   logic [W-1:0] tl_wd    [0:MAXT-1];
   logic         tl_xv    [0:MAXT-1];
   logic [W-1:0] tl_xd    [0:MAXT-1];
   logic         tl_wr    [0:MAXT-1];
   logic         tl_xr    [0:MAXT-1];
   logic         tl_busy  [0:MAXT-1];
   logic         tl_done  [0:MAXT-1];

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle(input logic [W-1:0] s_d, input logic s_v);
      if (cyc < MAXH) begin
         hist_d[cyc] = s_d;
         hist_v[cyc] = s_v;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // Lane k shows whatever entered stage 0 exactly k+1 cycles ago.
   function automatic logic [W-1:0] model_a_out();
      int src;
      model_a_out = '0;
      for (int k = 0; k < N; k++) begin
         src = cyc - k - 1;
         if (src >= base) model_a_out[k*DS +: DS] = hist_d[src][k*DS +: DS];
      end
   endfunction

   function automatic logic [N-1:0] model_a_vld();
      int src;
      model_a_vld = '0;
      for (int k = 0; k < N; k++) begin
         src = cyc - k - 1;
         if (src >= base) model_a_vld[k] = hist_v[src];
      end
   endfunction

   task automatic idle_inputs();
      start = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
      w_data = '0; x_data = '0; num_rows = '0;
   endtask

   // mode 0: no gaps; mode 1: two idle cycles before row 1; mode 2: random gaps everywhere.
   task automatic run_job(input int nrows, input int mode);
      int t, tt, ng;
      logic [W-1:0] cur_b, s_d;
      logic s_v, prev_beat;
      for (int i = 0; i < MAXT; i++) begin
         tl_start[i] = 1'b0; tl_wv[i] = 1'b0; tl_wd[i] = W'($urandom);
         tl_xv[i] = 1'b0; tl_xd[i] = W'($urandom);
         tl_wr[i] = 1'b0; tl_xr[i] = 1'b0; tl_busy[i] = 1'b1; tl_done[i] = 1'b0;
      end
      stall_exp = 0;
      tl_start[0] = 1'b1;
      tl_busy[0]  = 1'b0;
      t = 1;
      for (int b = 0; b < N; b++) begin
         ng = (mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < ng; g++) begin
            tl_wr[t] = 1'b1; tl_xv[t] = 1'($urandom_range(0, 1)); t++;
         end
         tl_wr[t] = 1'b1; tl_wv[t] = 1'b1; tl_wd[t] = w_rows[b];
         tl_xv[t] = 1'($urandom_range(0, 1)); t++;
      end
      for (int r = 0; r < nrows; r++) begin
         ng = (mode == 1 && r == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < ng; g++) begin
            tl_xr[t] = 1'b1; tl_wv[t] = 1'($urandom_range(0, 1)); stall_exp++; t++;
         end
         tl_xr[t] = 1'b1; tl_xv[t] = 1'b1; tl_xd[t] = x_rows[r];
         tl_wv[t] = 1'($urandom_range(0, 1)); t++;
      end
      for (int f = 0; f < 2 * N - 1; f++) begin
         tl_xv[t] = 1'($urandom_range(0, 1)); tl_wv[t] = 1'($urandom_range(0, 1)); t++;
      end
      tl_done[t] = 1'b1; t++;
      tl_busy[t] = 1'b0;
      tt = t + 1;

      cur_b = exp_b;
      prev_beat = 1'b0;
      for (t = 0; t < tt; t++) begin
         start    = tl_start[t];
         num_rows = (t == 0) ? RW'(nrows) : RW'($urandom);
         w_valid  = tl_wv[t]; w_data = tl_wd[t];
         x_valid  = tl_xv[t]; x_data = tl_xd[t];
         #1;
         checks++;
         if (w_ready !== tl_wr[t]) begin
            errors++; $display("FAIL w_ready cyc=%0d t=%0d got %b exp %b", cyc, t, w_ready, tl_wr[t]);
         end
         checks++;
         if (x_ready !== tl_xr[t]) begin
            errors++; $display("FAIL x_ready cyc=%0d t=%0d got %b exp %b", cyc, t, x_ready, tl_xr[t]);
         end
         checks++;
         if (busy !== tl_busy[t]) begin
            errors++; $display("FAIL busy cyc=%0d t=%0d got %b exp %b", cyc, t, busy, tl_busy[t]);
         end
         checks++;
         if (done !== tl_done[t]) begin
            errors++; $display("FAIL done cyc=%0d t=%0d got %b exp %b", cyc, t, done, tl_done[t]);
         end
         checks++;
         if (w_load !== prev_beat) begin
            errors++; $display("FAIL w_load cyc=%0d t=%0d got %b exp %b", cyc, t, w_load, prev_beat);
         end
         checks++;
         if (b_out !== cur_b) begin
            errors++; $display("FAIL b_out cyc=%0d t=%0d got %h exp %h", cyc, t, b_out, cur_b);
         end
         checks++;
         if (a_out !== model_a_out()) begin
            errors++; $display("FAIL a_out cyc=%0d t=%0d got %h exp %h", cyc, t, a_out, model_a_out());
         end
         checks++;
         if (a_vld !== model_a_vld()) begin
            errors++; $display("FAIL a_vld cyc=%0d t=%0d got %b exp %b", cyc, t, a_vld, model_a_vld());
         end
         s_v = tl_xr[t] && tl_xv[t];
         s_d = s_v ? tl_xd[t] : '0;
         prev_beat = tl_wr[t] && tl_wv[t];
         if (prev_beat) cur_b = tl_wd[t];
         next_cycle(s_d, s_v);
      end
      exp_b = cur_b;
      idle_inputs();
`ifdef FEEDER_STATS_EN
      checks++;
      if (stall_cnt !== 32'(stall_exp)) begin
         errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, stall_exp);
      end
`endif
   endtask

   task automatic load_spec_rows();
      w_rows[0] = 16'h0201;
      w_rows[1] = 16'h0403;
      x_rows.delete();
      x_rows.push_back(16'hB1A1);
      x_rows.push_back(16'hB2A2);
      x_rows.push_back(16'hB3A3);
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      start = 1'b1;
      num_rows = 16'd5;
      next_cycle('0, 1'b0);
      next_cycle('0, 1'b0);
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (a_out !== '0)     begin errors++; $display("FAIL reset_a_out got %h exp 0", a_out); end
      checks++; if (b_out !== '0)     begin errors++; $display("FAIL reset_b_out got %h exp 0", b_out); end
      checks++; if (a_vld !== 2'b00)  begin errors++; $display("FAIL reset_a_vld got %b exp 00", a_vld); end
      checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL reset_w_ready got %b exp 0", w_ready); end
      checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL reset_x_ready got %b exp 0", x_ready); end
      checks++; if (w_load !== 1'b0)  begin errors++; $display("FAIL reset_w_load got %b exp 0", w_load); end
`ifdef FEEDER_STATS_EN
      checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
`endif
      reset = 1'b0;
      start = 1'b0;
      base  = cyc;
      exp_b = '0;
      next_cycle('0, 1'b0);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL start_with_reset got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_load_and_stream();
      load_spec_rows();
      run_job(3, 0);
   endtask

   task automatic test_stall_gaps();
      load_spec_rows();
      run_job(3, 1);
   endtask

   task automatic test_zero_rows();
      load_spec_rows();
      run_job(0, 0);
   endtask

   task automatic test_random_jobs();
      int nr;
      for (int j = 0; j < 5; j++) begin
         for (int b = 0; b < N; b++) w_rows[b] = W'($urandom);
         nr = int'($urandom_range(1, 12));
         x_rows.delete();
         for (int r = 0; r < nr; r++) x_rows.push_back(W'($urandom));
         run_job(nr, 2);
      end
   endtask

   task automatic test_abort_mid_stream();
      load_spec_rows();
      start = 1'b1; num_rows = 16'd3;
      next_cycle('0, 1'b0);
      start = 1'b0;
      w_valid = 1'b1; w_data = w_rows[0];
      next_cycle('0, 1'b0);
      w_data = w_rows[1];
      next_cycle('0, 1'b0);
      w_valid = 1'b0;
      x_valid = 1'b1; x_data = x_rows[0];
      checks++;
      if (x_ready !== 1'b1) begin
         errors++; $display("FAIL abort_x_ready got %b exp 1", x_ready);
      end
      next_cycle(x_rows[0], 1'b1);
      reset = 1'b1; x_data = x_rows[1];
      next_cycle('0, 1'b0);
      reset = 1'b0;
      idle_inputs();
      base  = cyc;
      exp_b = '0;
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      checks++; if (b_out !== '0)    begin errors++; $display("FAIL abort_b_out got %h exp 0", b_out); end
      checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL abort_x_ready_low got %b exp 0", x_ready); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (done !== 1'b0)  begin errors++; $display("FAIL abort_done i=%0d got %b exp 0", i, done); end
         checks++; if (a_vld !== '0)   begin errors++; $display("FAIL abort_a_vld i=%0d got %b exp 00", i, a_vld); end
         checks++; if (a_out !== '0)   begin errors++; $display("FAIL abort_a_out i=%0d got %h exp 0", i, a_out); end
         next_cycle('0, 1'b0);
      end
      load_spec_rows();
      run_job(3, 0);
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_load_and_stream();
      test_stall_gaps();
      test_zero_rows();
      test_random_jobs();
      test_abort_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
